// File: rtl/ni_read_resp_gen.sv
// NI read-response generator: issues activation-memory reads for dequeued read
// requests and returns the data as router flits. Optional macro: NI_READ_RESP_BYPASS_EN.
module ni_read_resp_gen #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RESP_DEPTH = 4,
  parameter logic [3:0]  RESP_INFO  = 4'd3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ni_read_rqst,
  input  logic [ADDR_WIDTH-1:0] ni_read_addr,
  output logic                  router_rdy,
  output logic                  act_mem_read_en,
  output logic [ADDR_WIDTH-1:0] act_mem_read_addr,
  input  logic [DATA_WIDTH-1:0] act_mem_read_data,
  output logic                  out_data_valid,
  output logic [35:0]           out_data,
  input  logic                  out_rdy,
  output logic                  resp_overflow
);

  localparam int unsigned PW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [EW-1:0]         fifo_mem [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic [EW-1:0]         head;
  logic [SW-1:0]         inflight;
`ifdef NI_READ_RESP_BYPASS_EN
  logic                  bypass_take;
`endif

  function automatic logic [35:0] make_flit(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] d);
    return {RESP_INFO, 16'(a), d};
  endfunction

  // Memory issue, FIFO control and flit output
  always_comb begin
    act_mem_read_en   = ni_read_rqst & ~rst;
    act_mem_read_addr = ni_read_addr;
    fifo_empty        = (count == '0);
    fifo_full         = (count == CW'(RESP_DEPTH));
    head              = fifo_mem[rd_ptr];
    pop               = ~fifo_empty & out_rdy;
`ifdef NI_READ_RESP_BYPASS_EN
    // Empty FIFO: present the fresh memory word directly, skip the write if taken
    bypass_take       = s1_valid & fifo_empty & out_rdy;
    push              = s1_valid & ~bypass_take;
    out_data_valid    = ~fifo_empty | s1_valid;
    if (!fifo_empty)
      out_data = make_flit(head[EW-1:DATA_WIDTH], head[DATA_WIDTH-1:0]);
    else if (s1_valid)
      out_data = make_flit(s1_addr, act_mem_read_data);
    else
      out_data = '0;
`else
    push              = s1_valid;
    out_data_valid    = ~fifo_empty;
    out_data          = fifo_empty ? 36'd0
                                   : make_flit(head[EW-1:DATA_WIDTH], head[DATA_WIDTH-1:0]);
`endif
    push_ok           = push & (~fifo_full | pop);
    drop              = push & fifo_full & ~pop;
    // Credit counts queued, in-flight and currently presented requests; same-cycle pops ignored
    inflight          = SW'(count) + SW'(s1_valid) + SW'(ni_read_rqst);
    router_rdy        = (inflight <= SW'(RESP_DEPTH - 1));
  end

  // Stage s1, FIFO pointers/occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      resp_overflow <= 1'b0;
    end else begin
      s1_valid <= act_mem_read_en;
      s1_addr  <= ni_read_addr;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) resp_overflow <= 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok && !rst) fifo_mem[wr_ptr] <= {s1_addr, act_mem_read_data};
  end

endmodule

// File: tb/tb_ni_read_resp_gen.sv
// Directed self-checking bench for ni_read_resp_gen with a 1-cycle activation memory model.
module tb_ni_read_resp_gen;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
`ifdef NI_READ_RESP_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ni_read_rqst;
  logic [AW-1:0] ni_read_addr;
  logic          router_rdy;
  logic          act_mem_read_en;
  logic [AW-1:0] act_mem_read_addr;
  logic [DW-1:0] act_mem_read_data;
  logic          out_data_valid;
  logic [35:0]   out_data;
  logic          out_rdy;
  logic          resp_overflow;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mem [64];

  ni_read_resp_gen dut (
    .clk(clk), .rst(rst),
    .ni_read_rqst(ni_read_rqst), .ni_read_addr(ni_read_addr),
    .router_rdy(router_rdy),
    .act_mem_read_en(act_mem_read_en), .act_mem_read_addr(act_mem_read_addr),
    .act_mem_read_data(act_mem_read_data),
    .out_data_valid(out_data_valid), .out_data(out_data), .out_rdy(out_rdy),
    .resp_overflow(resp_overflow)
  );

  always #5 clk = ~clk;

  // Activation memory: one cycle read latency
  always @(posedge clk) if (act_mem_read_en) act_mem_read_data <= mem[act_mem_read_addr];

  function automatic logic [35:0] flit(input logic [AW-1:0] a);
    return {4'h3, 10'h000, a, mem[a]};
  endfunction

  task automatic cyc(input logic rq, input logic [AW-1:0] a, input logic ordy);
    @(negedge clk);
    ni_read_rqst = rq; ni_read_addr = a; out_rdy = ordy;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; ni_read_rqst = 1'b0; ni_read_addr = '0; out_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill4;
    for (int i = 1; i <= 4; i++) cyc(1'b1, AW'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; ni_read_rqst = 1'b1; ni_read_addr = 6'h2A; out_rdy = 1'b0;
    #1;
    checks++; if (act_mem_read_en !== 1'b0) begin errors++; $display("FAIL rst_en_gated: got %b exp 0", act_mem_read_en); end
    @(negedge clk); ni_read_rqst = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", out_data_valid); end
    checks++; if (out_data !== 36'd0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_data); end
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", resp_overflow); end
    checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b exp 1", router_rdy); end
    checks++; if (act_mem_read_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b exp 0", act_mem_read_en); end
  endtask

  task automatic test_single;
    do_reset();
    cyc(1'b1, 6'h05, 1'b1);
    checks++; if (act_mem_read_en !== 1'b1) begin errors++; $display("FAIL single_en: got %b exp 1", act_mem_read_en); end
    checks++; if (act_mem_read_addr !== 6'h05) begin errors++; $display("FAIL single_addr: got %h exp 05", act_mem_read_addr); end
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t0: got %b exp 0", out_data_valid); end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== (k == LAT)) begin errors++; $display("FAIL single_valid_t%0d: got %b exp %b", k, out_data_valid, (k == LAT)); end
      checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy_t%0d: got %b exp 1", k, router_rdy); end
      if (k == LAT) begin
        checks++; if (out_data !== 36'h3_0005_BEEF) begin errors++; $display("FAIL single_data: got %h exp 30005beef", out_data); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rv;
    rv = 4'b0111;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, AW'(i + 1), 1'b0);
      checks++; if (router_rdy !== rv[i]) begin errors++; $display("FAIL b2b_rdy_%0d: got %b exp %b", i, router_rdy, rv[i]); end
    end
    cyc(1'b0, '0, 1'b0);
    checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_hold: got %b exp 0", router_rdy); end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== 1'b1 || out_data !== flit(AW'(i))) begin errors++; $display("FAIL b2b_drain_%0d: got %b/%h exp 1/%h", i, out_data_valid, out_data, flit(AW'(i))); end
      checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_%0d: got %b exp 0", i, resp_overflow); end
      if (i == 1) begin
        checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full_pop: got %b exp 0", router_rdy); end
      end
    end
    cyc(1'b0, '0, 1'b1);
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", out_data_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [AW-1:0] ord [4];
    ord[0] = 6'd2; ord[1] = 6'd3; ord[2] = 6'd4; ord[3] = 6'd10;
    do_reset();
    fill4();
    cyc(1'b1, 6'd10, 1'b0);
    checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL fpp_rdy_full: got %b exp 0", router_rdy); end
    cyc(1'b0, '0, 1'b1);
    checks++; if (out_data !== flit(6'd1)) begin errors++; $display("FAIL fpp_head: got %h exp %h", out_data, flit(6'd1)); end
    cyc(1'b0, '0, 1'b0);
    checks++; if (router_rdy !== 1'b0) begin errors++; $display("FAIL fpp_count_kept: got rdy %b exp 0", router_rdy); end
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b exp 0", resp_overflow); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== 1'b1 || out_data !== flit(ord[i])) begin errors++; $display("FAIL fpp_order_%0d: got %b/%h exp 1/%h", i, out_data_valid, out_data, flit(ord[i])); end
    end
    cyc(1'b0, '0, 1'b0);
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b exp 0", out_data_valid); end
  endtask

  task automatic test_overflow;
    do_reset();
    fill4();
    cyc(1'b1, 6'd20, 1'b0);
    cyc(1'b0, '0, 1'b0);
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b exp 0", resp_overflow); end
    cyc(1'b0, '0, 1'b0);
    checks++; if (resp_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", resp_overflow); end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data !== flit(AW'(i))) begin errors++; $display("FAIL ovf_drain_%0d: got %h exp %h", i, out_data, flit(AW'(i))); end
    end
    cyc(1'b0, '0, 1'b1);
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b exp 0", out_data_valid); end
    checks++; if (resp_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", resp_overflow); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b exp 0", resp_overflow); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, AW'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1; ni_read_rqst = 1'b0; out_rdy = 1'b0;
    #1;
    checks++; if (out_data_valid !== 1'b1 || out_data !== flit(6'd1)) begin errors++; $display("FAIL midrst_pre: got %b/%h exp 1/%h", out_data_valid, out_data, flit(6'd1)); end
    @(negedge clk);
    rst = 1'b0; out_rdy = 1'b1;
    #1;
    checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", out_data_valid); end
    checks++; if (router_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b exp 1", router_rdy); end
    checks++; if (out_data !== 36'd0) begin errors++; $display("FAIL midrst_data: got %h exp 0", out_data); end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d: got %b exp 0", k, out_data_valid); end
    end
    cyc(1'b1, 6'd7, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== (k == LAT)) begin errors++; $display("FAIL midrst_new_valid_%0d: got %b exp %b", k, out_data_valid, (k == LAT)); end
      if (k == LAT) begin
        checks++; if (out_data !== flit(6'd7)) begin errors++; $display("FAIL midrst_new_data: got %h exp %h", out_data, flit(6'd7)); end
      end
    end
  endtask

  task automatic test_toggle;
    logic [AW-1:0] exp_q [$];
    int            issued;
    int            got;
    logic          prev_rdy;
    logic          held;
    logic [35:0]   held_data;
    issued = 0; got = 0; prev_rdy = 1'b1; held = 1'b0; held_data = '0;
    do_reset();
    for (int n = 0; n < 100 && got < 8; n++) begin
      @(negedge clk);
      if (issued < 8 && prev_rdy) begin
        ni_read_rqst = 1'b1; ni_read_addr = AW'(30 + issued);
        exp_q.push_back(AW'(30 + issued)); issued++;
      end else begin
        ni_read_rqst = 1'b0;
      end
      out_rdy = (n % 2 == 0);
      #1;
      prev_rdy = router_rdy;
      if (held) begin
        checks++; if (out_data_valid !== 1'b1 || out_data !== held_data) begin errors++; $display("FAIL tog_stable: got %b/%h exp 1/%h", out_data_valid, out_data, held_data); end
      end
      held = 1'b0;
      if (out_data_valid === 1'b1) begin
        if (out_rdy) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL tog_extra: got %h exp none", out_data); end
          else begin
            if (out_data !== flit(exp_q[0])) begin errors++; $display("FAIL tog_data_%0d: got %h exp %h", got, out_data, flit(exp_q[0])); end
            void'(exp_q.pop_front());
          end
          got++;
        end else begin
          held = 1'b1; held_data = out_data;
        end
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL tog_timeout: got %0d flits exp 8", got); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (out_data_valid !== 1'b0) begin errors++; $display("FAIL tog_dup_%0d: got %b exp 0", k, out_data_valid); end
    end
    checks++; if (resp_overflow !== 1'b0) begin errors++; $display("FAIL tog_ovf: got %b exp 0", resp_overflow); end
  endtask

  initial begin
    rst = 1'b1; ni_read_rqst = 1'b0; ni_read_addr = '0; out_rdy = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 16'hD000 + 16'(i);
    mem[5] = 16'hBEEF;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
